peri_sample_fifo: RTL

//  Downstream stage of the MEMS microphone peripheral: captures each 8-bit PDM density sample
//  (sample_i, qualified by the one-cycle sample_valid_i pulse, i.e. the mic irq_o) into a FIFO.
//  The CPU drains the FIFO over Wishbone B4 instead of servicing every sample.

---
 rtl/peri_sample_fifo_pkg.sv | 23 ++
 rtl/peri_sample_fifo_sync_fifo.sv | 65 ++++++
 rtl/peri_sample_fifo.sv | 135 +++++++++++++
 3 files changed

// File: rtl/peri_sample_fifo_pkg.sv
// Package: peri_sample_fifo_pkg
// Shared register map for the microphone sample FIFO peripheral: Wishbone
// register addresses, STATUS bit positions and CTRL bit positions.
package peri_sample_fifo_pkg;

  localparam logic [3:0] ADR_DATA   = 4'h0;
  localparam logic [3:0] ADR_STATUS = 4'h1;
  localparam logic [3:0] ADR_COUNT  = 4'h2;
  localparam logic [3:0] ADR_THRESH = 4'h3;
  localparam logic [3:0] ADR_CTRL   = 4'h4;

  localparam int STATUS_OVERFLOW  = 7;
  localparam int STATUS_UNDERFLOW = 6;
  localparam int STATUS_EMPTY     = 5;
  localparam int STATUS_FULL      = 4;
  localparam int STATUS_IRQ       = 3;
  localparam int STATUS_ENABLE    = 2;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLRFLAG = 1;
  localparam int CTRL_ENABLE  = 2;

endpackage

// File: rtl/peri_sample_fifo_sync_fifo.sv
// Module: sync_fifo
// Single-clock circular FIFO with push, pop and flush.
// Ports:
//   clk    in   clock, all state on posedge
//   rst    in   synchronous active-high reset
//   push   in   store din (done only if not full, or full with a same-cycle pop)
//   pop    in   discard head entry (done only if not empty)
//   flush  in   empty the FIFO; overrides push and pop in the same cycle
//   din    in   write data
//   dout   out  head entry (undefined content when empty)
//   full   out  count == Depth
//   empty  out  count == 0
//   count  out  number of stored entries, 0..Depth
module sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 16,
  parameter int PtrW  = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PtrW:0]    count
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW-1:0]  wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign full  = (count == (PtrW+1)'(Depth));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle,
  // so the freed slot is reused and the count stays put.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/peri_sample_fifo.sv
// Module: peri_sample_fifo
// Buffers 8-bit PDM density samples from the microphone peripheral and lets
// the CPU drain them over a zero-wait-state Wishbone B4 slave. Adds a level
// threshold interrupt, sticky overflow/underflow flags and a flush command.
// Ports:
//   clk_i           in   clock
//   rst_i           in   synchronous active-high reset
//   sample_i        in   sample value
//   sample_valid_i  in   one-cycle push pulse
//   wb_we_i         in   Wishbone write enable
//   wb_stb_i        in   Wishbone strobe
//   wb_ack_o        out  mirrors wb_stb_i
//   wb_adr_i        in   register address
//   wb_dat_i        in   write data
//   wb_dat_o        out  combinational read data
//   irq_o           out  level interrupt: THRESH != 0 && count >= THRESH
module peri_sample_fifo
  import peri_sample_fifo_pkg::*;
#(
  parameter int Depth = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] sample_i,
  input  logic       sample_valid_i,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  output logic       wb_ack_o,
  input  logic [3:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       irq_o
);

  localparam int PtrW = $clog2(Depth);

  logic            enable;
  logic [7:0]      thresh;
  logic            overflow;
  logic            underflow;
  logic [7:0]      head;
  logic            full;
  logic            empty;
  logic [PtrW:0]   count;
  logic [7:0]      count8;

  logic            rd_access;
  logic            wr_access;
  logic            data_rd;
  logic            ctrl_wr;
  logic            flush;
  logic            clrflag;
  logic            push_req;
  logic            overflow_evt;
  logic            underflow_evt;

  assign wb_ack_o  = wb_stb_i;
  assign rd_access = wb_stb_i && !wb_we_i;
  assign wr_access = wb_stb_i && wb_we_i;
  assign data_rd   = rd_access && (wb_adr_i == ADR_DATA);
  assign ctrl_wr   = wr_access && (wb_adr_i == ADR_CTRL);
  assign flush     = ctrl_wr && wb_dat_i[CTRL_FLUSH];
  assign clrflag   = ctrl_wr && wb_dat_i[CTRL_CLRFLAG];
  assign push_req  = sample_valid_i && enable;
  assign count8    = 8'(count);

  // Flush suppresses both events: the pushed sample is dropped silently and a
  // DATA read that cycle still sees the current head, so nothing underflows.
  // A push into a full FIFO only overflows when no pop frees a slot.
  assign overflow_evt  = push_req && full && !(data_rd && !empty) && !flush;
  assign underflow_evt = data_rd && empty && !flush;

  sync_fifo #(
    .Width (8),
    .Depth (Depth)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push_req),
    .pop   (data_rd),
    .flush (flush),
    .din   (sample_i),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Control registers; CTRL writes always store ENABLE, whatever else they do.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable <= 1'b1;
      thresh <= 8'h00;
    end else begin
      if (ctrl_wr) enable <= wb_dat_i[CTRL_ENABLE];
      if (wr_access && (wb_adr_i == ADR_THRESH)) thresh <= wb_dat_i;
    end
  end

  // Sticky flags: a new event outranks a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (overflow_evt)  overflow <= 1'b1;
      else if (clrflag)  overflow <= 1'b0;
      if (underflow_evt) underflow <= 1'b1;
      else if (clrflag)  underflow <= 1'b0;
    end
  end

  // Count is at most Depth, so a threshold above Depth can never be reached.
  assign irq_o = (thresh != 8'h00) && (count8 >= thresh);

  always_comb begin
    wb_dat_o = 8'h00;
    unique case (wb_adr_i)
      ADR_DATA:   wb_dat_o = empty ? 8'h00 : head;
      ADR_STATUS: begin
        wb_dat_o[STATUS_OVERFLOW]  = overflow;
        wb_dat_o[STATUS_UNDERFLOW] = underflow;
        wb_dat_o[STATUS_EMPTY]     = empty;
        wb_dat_o[STATUS_FULL]      = full;
        wb_dat_o[STATUS_IRQ]       = irq_o;
        wb_dat_o[STATUS_ENABLE]    = enable;
      end
      ADR_COUNT:  wb_dat_o = count8;
      ADR_THRESH: wb_dat_o = thresh;
      ADR_CTRL:   wb_dat_o[CTRL_ENABLE] = enable;
      default:    wb_dat_o = 8'h00;
    endcase
  end

endmodule
